// File: rtl/onewire_slave_seq.sv
`default_nettype none
// ============================================================================
//  Module      : onewire_slave_seq
//  Description : 1-Wire slave command sequencer. Filters decoded 56-bit
//                commands by device address, executes register reads and
//                writes, builds the 56-bit response frame for the transmit
//                path and keeps a saturating error/drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module onewire_slave_seq #(
    parameter logic [7:0] DEV_ADDR   = 8'h01,
    parameter logic [7:0] BCAST_ADDR = 8'hFF,
    parameter int         RD_TIMEOUT = 16,
    parameter int         TX_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cmd_valid,
    input  logic [55:0] i_command,
    input  logic        i_crc_error,
    output logic        o_reg_we,
    output logic        o_reg_re,
    output logic [7:0]  o_reg_addr,
    output logic [31:0] o_reg_wdata,
    input  logic [31:0] i_reg_rdata,
    input  logic        i_reg_rvalid,
    output logic        o_tx_req,
    output logic [55:0] o_tx_frame,
    input  logic        i_tx_done,
    output logic        o_busy,
    output logic [2:0]  o_status,
    output logic [7:0]  o_err_count
);

    // Opcodes
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_PING  = 8'h03;
    localparam logic [7:0] OP_BAD   = 8'hEE;

    // Status codes
    localparam logic [2:0] ST_OK     = 3'd0;
    localparam logic [2:0] ST_CRC    = 3'd1;
    localparam logic [2:0] ST_BADOP  = 3'd2;
    localparam logic [2:0] ST_RD_TO  = 3'd3;
    localparam logic [2:0] ST_TX_TO  = 3'd4;
    localparam logic [2:0] ST_DROP   = 3'd5;

    // One shared wait counter, wide enough for the longer of the two timeouts
    localparam int              CNT_MAX = (RD_TIMEOUT > TX_TIMEOUT) ? RD_TIMEOUT : TX_TIMEOUT;
    localparam int              CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_EXEC    = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RESP    = 3'd4,
        S_TX_WAIT = 3'd5
    } state_t;

    state_t             state;
    logic [55:0]        cmd;
    logic               crc_err;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        resp_data;

    // Fields of the latched command
    logic [7:0]  cmd_op;
    logic [7:0]  cmd_dev;
    logic [7:0]  cmd_reg;
    logic [31:0] cmd_data;

    assign cmd_op   = cmd[55:48];
    assign cmd_dev  = cmd[47:40];
    assign cmd_reg  = cmd[39:32];
    assign cmd_data = cmd[31:0];

    // Address and opcode classification of the latched command
    logic is_bcast;
    logic addr_hit;
    logic op_valid;

    assign is_bcast = (cmd_dev == BCAST_ADDR);
    assign addr_hit = (cmd_dev == DEV_ADDR) || is_bcast;
    assign op_valid = (cmd_op == OP_WRITE) || (cmd_op == OP_READ) || (cmd_op == OP_PING);

    // A new command can only be taken when the registered state is IDLE;
    // anything arriving earlier, including the cycle we return to IDLE, is dropped.
    logic drop_evt;
    assign drop_evt = i_cmd_valid && (state != S_IDLE);

    // Error events raised by the in-flight command this cycle
    logic fsm_err;
    assign fsm_err = ((state == S_CHECK)   && (crc_err || (addr_hit && !op_valid)))
                  || ((state == S_RD_WAIT) && !i_reg_rvalid && (cnt == RD_LAST))
                  || ((state == S_TX_WAIT) && !i_tx_done    && (cnt == TX_LAST));

    // Up to two events per cycle: one from the FSM and one dropped command
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    assign err_inc = {1'b0, fsm_err} + {1'b0, drop_evt};
    assign err_sum = {1'b0, o_err_count} + {7'b0, err_inc};

    assign o_busy = (state != S_IDLE);

    // Saturating error counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_err_count <= 8'h00;
        end else begin
            o_err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    // Command sequencer: filter, execute, respond, with timeouts on both waits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cmd         <= 56'h0;
            crc_err     <= 1'b0;
            cnt         <= '0;
            resp_data   <= 32'h0;
            o_reg_we    <= 1'b0;
            o_reg_re    <= 1'b0;
            o_reg_addr  <= 8'h00;
            o_reg_wdata <= 32'h0;
            o_tx_req    <= 1'b0;
            o_tx_frame  <= 56'h0;
            o_status    <= ST_OK;
        end else begin
            // Strobes are single-cycle; the counter restarts on every state entry
            o_reg_we <= 1'b0;
            o_reg_re <= 1'b0;
            cnt      <= '0;

            // A dropped command reports 5 unless the in-flight command
            // writes its own final status in the same cycle (below).
            if (drop_evt) begin
                o_status <= ST_DROP;
            end

            case (state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        cmd     <= i_command;
                        crc_err <= i_crc_error;
                        state   <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (crc_err) begin
                        o_status <= ST_CRC;
                        state    <= S_IDLE;
                    end else if (!addr_hit) begin
                        state <= S_IDLE;
                    end else if (!op_valid) begin
                        o_status <= ST_BADOP;
                        state    <= is_bcast ? S_IDLE : S_RESP;
                    end else if (is_bcast && (cmd_op != OP_WRITE)) begin
                        state <= S_IDLE;
                    end else begin
                        // Strobes are registered so they line up with EXEC
                        o_reg_addr <= cmd_reg;
                        if (cmd_op == OP_WRITE) begin
                            o_reg_we    <= 1'b1;
                            o_reg_wdata <= cmd_data;
                        end
                        if (cmd_op == OP_READ) begin
                            o_reg_re <= 1'b1;
                        end
                        state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (cmd_op == OP_WRITE) begin
                        if (is_bcast) begin
                            o_status <= ST_OK;
                            state    <= S_IDLE;
                        end else begin
                            resp_data <= cmd_data;
                            state     <= S_RESP;
                        end
                    end else if (cmd_op == OP_READ) begin
                        state <= S_RD_WAIT;
                    end else begin
                        resp_data <= 32'h0;
                        state     <= S_RESP;
                    end
                end

                S_RD_WAIT: begin
                    if (i_reg_rvalid) begin
                        resp_data <= i_reg_rdata;
                        state     <= S_RESP;
                    end else if (cnt == RD_LAST) begin
                        o_status <= ST_RD_TO;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    o_tx_req <= 1'b1;
                    if (op_valid) begin
                        o_tx_frame <= {cmd_op | 8'h80, DEV_ADDR, cmd_reg, resp_data};
                    end else begin
                        o_tx_frame <= {OP_BAD, DEV_ADDR, cmd_op, 24'h0};
                    end
                    state <= S_TX_WAIT;
                end

                S_TX_WAIT: begin
                    if (i_tx_done) begin
                        o_tx_req <= 1'b0;
                        o_status <= op_valid ? ST_OK : ST_BADOP;
                        state    <= S_IDLE;
                    end else if (cnt == TX_LAST) begin
                        o_tx_req <= 1'b0;
                        o_status <= ST_TX_TO;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onewire_slave_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onewire_slave_seq
//  Description : Self-checking bench for onewire_slave_seq: directed vector
//                table, hand-written corner sequences and randomized commands
//                checked against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onewire_slave_seq;

    localparam int RD_TIMEOUT = 16;
    localparam int TX_TIMEOUT = 4096;
    localparam int NO_RESP    = 100000;
    localparam int MAX_CYC    = 6000;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_cmd_valid;
    logic [55:0] i_command;
    logic        i_crc_error;
    logic        o_reg_we;
    logic        o_reg_re;
    logic [7:0]  o_reg_addr;
    logic [31:0] o_reg_wdata;
    logic [31:0] i_reg_rdata;
    logic        i_reg_rvalid;
    logic        o_tx_req;
    logic [55:0] o_tx_frame;
    logic        i_tx_done;
    logic        o_busy;
    logic [2:0]  o_status;
    logic [7:0]  o_err_count;

    always #5 clk = ~clk;

    onewire_slave_seq #(
        .DEV_ADDR   (8'h01),
        .BCAST_ADDR (8'hFF),
        .RD_TIMEOUT (RD_TIMEOUT),
        .TX_TIMEOUT (TX_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_cmd_valid  (i_cmd_valid),
        .i_command    (i_command),
        .i_crc_error  (i_crc_error),
        .o_reg_we     (o_reg_we),
        .o_reg_re     (o_reg_re),
        .o_reg_addr   (o_reg_addr),
        .o_reg_wdata  (o_reg_wdata),
        .i_reg_rdata  (i_reg_rdata),
        .i_reg_rvalid (i_reg_rvalid),
        .o_tx_req     (o_tx_req),
        .o_tx_frame   (o_tx_frame),
        .i_tx_done    (i_tx_done),
        .o_busy       (o_busy),
        .o_status     (o_status),
        .o_err_count  (o_err_count)
    );

    // One command with its stimulus and expected transaction-level outcome
    typedef struct {
        logic [55:0] cmd;
        bit          crc;
        int          rd_lat;   // cycles after the re strobe to pulse rvalid
        logic [31:0] rdata;
        int          tx_dly;   // cycles after tx_req rises to pulse tx_done
        bit          we;
        bit          re;
        bit          tx;
        logic [55:0] frame;
        int          lat;      // cycles from cmd_valid to tx_req, -1 = unchecked
        logic [2:0]  status;
        logic [7:0]  err;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations collected by run_cmd
    int          obs_we, obs_re, obs_tx_n, obs_drop_n;
    bit          obs_unstable, obs_done;
    logic [7:0]  obs_waddr, obs_raddr;
    logic [31:0] obs_wdata;
    logic [55:0] obs_frame;

    // Reference model state
    logic [2:0]  m_status;
    int          m_err;

    vec_t tbl[$];
    vec_t cur, expv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [55:0] cmd, input bit crc, input int rd_lat,
                           input logic [31:0] rdata, input int tx_dly, input bit we,
                           input bit re, input bit tx, input logic [55:0] frame,
                           input int lat, input logic [2:0] status, input logic [7:0] err);
        vec_t v;
        v.cmd = cmd; v.crc = crc; v.rd_lat = rd_lat; v.rdata = rdata; v.tx_dly = tx_dly;
        v.we = we; v.re = re; v.tx = tx; v.frame = frame; v.lat = lat;
        v.status = status; v.err = err;
        tbl.push_back(v);
    endtask

    // Drive one command and play the register file / transmit path around it
    task automatic run_cmd(input logic [55:0] c, input bit crc, input int rd_lat,
                           input logic [31:0] rdata, input int tx_dly,
                           input bit inj, input logic [55:0] inj_cmd);
        int re_n;
        obs_we = 0; obs_re = 0; obs_tx_n = -1; obs_drop_n = -1;
        obs_unstable = 1'b0; obs_done = 1'b0;
        obs_waddr = 8'h0; obs_raddr = 8'h0; obs_wdata = 32'h0; obs_frame = 56'h0;
        re_n = -1;
        @(negedge clk);
        i_command   = c;
        i_crc_error = crc;
        i_cmd_valid = 1'b1;
        for (int n = 1; n < MAX_CYC; n++) begin
            @(negedge clk);
            i_cmd_valid  = 1'b0;
            i_crc_error  = 1'b0;
            i_reg_rvalid = 1'b0;
            i_tx_done    = 1'b0;
            i_reg_rdata  = $urandom();
            if (o_reg_we) begin
                obs_we++;
                obs_waddr = o_reg_addr;
                obs_wdata = o_reg_wdata;
            end
            if (o_reg_re) begin
                obs_re++;
                obs_raddr = o_reg_addr;
                re_n = n;
            end
            if (re_n >= 0 && n == re_n + rd_lat) begin
                i_reg_rvalid = 1'b1;
                i_reg_rdata  = rdata;
            end
            if (o_tx_req) begin
                if (obs_tx_n < 0) begin
                    obs_tx_n  = n;
                    obs_frame = o_tx_frame;
                end else if (o_tx_frame !== obs_frame) begin
                    obs_unstable = 1'b1;
                end
                if (n == obs_tx_n + tx_dly) i_tx_done = 1'b1;
                if (inj && n == obs_tx_n + 1) begin
                    i_cmd_valid = 1'b1;
                    i_command   = inj_cmd;
                end
            end else if (obs_tx_n >= 0 && obs_drop_n < 0) begin
                obs_drop_n = n;
            end
            if (!o_busy && !o_tx_req && (re_n < 0 || n > re_n + rd_lat)) begin
                obs_done = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_txn(input string tag, input vec_t v);
        int hold;
        chk({tag, ".completed"}, obs_done, 1);
        chk({tag, ".we_pulses"}, obs_we, v.we);
        if (v.we) begin
            chk({tag, ".we_addr"}, obs_waddr, v.cmd[39:32]);
            chk({tag, ".we_data"}, obs_wdata, v.cmd[31:0]);
        end
        chk({tag, ".re_pulses"}, obs_re, v.re);
        if (v.re) chk({tag, ".re_addr"}, obs_raddr, v.cmd[39:32]);
        chk({tag, ".tx_seen"}, obs_tx_n >= 0, v.tx);
        if (v.tx) begin
            chk({tag, ".frame"}, obs_frame, v.frame);
            chk({tag, ".frame_stable"}, obs_unstable, 0);
            if (v.lat >= 0) chk({tag, ".latency"}, obs_tx_n, v.lat);
            hold = (v.tx_dly < TX_TIMEOUT) ? v.tx_dly + 1 : TX_TIMEOUT;
            chk({tag, ".tx_hold"}, obs_drop_n - obs_tx_n, hold);
        end
        chk({tag, ".status"}, o_status, v.status);
        chk({tag, ".err_count"}, o_err_count, v.err);
        chk({tag, ".busy_end"}, o_busy, 0);
    endtask

    // Transaction-level reference: outcome of one command from the protocol rules
    task automatic model(input vec_t vi, output vec_t vo);
        logic [7:0]  op, dev, ra;
        logic [31:0] d;
        int          inc;
        vo = vi;
        op = vi.cmd[55:48]; dev = vi.cmd[47:40]; ra = vi.cmd[39:32]; d = vi.cmd[31:0];
        vo.we = 0; vo.re = 0; vo.tx = 0; vo.frame = 56'h0; vo.lat = -1;
        inc = 0;
        if (vi.crc) begin
            m_status = 3'd1; inc = 1;
        end else if (dev != 8'h01 && dev != 8'hFF) begin
            inc = 0;
        end else if (!(op inside {8'h01, 8'h02, 8'h03})) begin
            m_status = 3'd2; inc = 1;
            if (dev != 8'hFF) begin
                vo.tx = 1; vo.frame = {8'hEE, 8'h01, op, 24'h0};
            end
        end else if (dev == 8'hFF) begin
            if (op == 8'h01) begin
                vo.we = 1; m_status = 3'd0;
            end
        end else if (op == 8'h01) begin
            vo.we = 1; vo.tx = 1; vo.frame = {8'h81, 8'h01, ra, d}; vo.lat = 4; m_status = 3'd0;
        end else if (op == 8'h02) begin
            vo.re = 1;
            if (vi.rd_lat <= RD_TIMEOUT) begin
                vo.tx = 1; vo.frame = {8'h82, 8'h01, ra, vi.rdata};
                vo.lat = 4 + vi.rd_lat; m_status = 3'd0;
            end else begin
                m_status = 3'd3; inc = 1;
            end
        end else begin
            vo.tx = 1; vo.frame = {8'h83, 8'h01, ra, 32'h0}; vo.lat = 4; m_status = 3'd0;
        end
        if (vo.tx && vi.tx_dly >= TX_TIMEOUT) begin
            m_status = 3'd4; inc++;
        end
        m_err = (m_err + inc > 255) ? 255 : m_err + inc;
        vo.status = m_status;
        vo.err    = 8'(m_err);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".reg_we"}, o_reg_we, 0);
        chk({tag, ".reg_re"}, o_reg_re, 0);
        chk({tag, ".reg_addr"}, o_reg_addr, 0);
        chk({tag, ".reg_wdata"}, o_reg_wdata, 0);
        chk({tag, ".tx_req"}, o_tx_req, 0);
        chk({tag, ".tx_frame"}, o_tx_frame, 0);
        chk({tag, ".busy"}, o_busy, 0);
        chk({tag, ".status"}, o_status, 0);
        chk({tag, ".err_count"}, o_err_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; i_cmd_valid = 1'b0; i_command = 56'h0; i_crc_error = 1'b0;
        i_reg_rdata = 32'h0; i_reg_rvalid = 1'b0; i_tx_done = 1'b0;

        // Directed vectors, absolute status/err expectations from reset
        //       command                 crc lat rdata         txd we re tx frame                     lat st  err
        add_vec(56'h01_01_10_DEADBEEF, 0,  0, 32'h0,         2, 1, 0, 1, 56'h81_01_10_DEADBEEF,  4, 3'd0, 8'd0);
        add_vec(56'h02_01_22_00000000, 0,  3, 32'h12345678,  1, 0, 1, 1, 56'h82_01_22_12345678,  7, 3'd0, 8'd0);
        add_vec(56'h02_01_22_00000000, 0, 40, 32'h0BADF00D,  1, 0, 1, 0, 56'h0,                 -1, 3'd3, 8'd1);
        add_vec(56'h01_05_10_00000001, 0,  0, 32'h0,         1, 0, 0, 0, 56'h0,                 -1, 3'd3, 8'd1);
        add_vec(56'h01_FF_10_00000001, 0,  0, 32'h0,         1, 1, 0, 0, 56'h0,                 -1, 3'd0, 8'd1);
        add_vec(56'h02_FF_10_00000000, 0,  2, 32'h55AA55AA,  1, 0, 0, 0, 56'h0,                 -1, 3'd0, 8'd1);
        add_vec(56'h03_01_00_00000000, 1,  0, 32'h0,         1, 0, 0, 0, 56'h0,                 -1, 3'd1, 8'd2);
        add_vec(56'h7A_01_33_12345678, 0,  0, 32'h0,         1, 0, 0, 1, 56'hEE_01_7A_000000,   -1, 3'd2, 8'd3);
        add_vec(56'h03_01_44_ABCDEF01, 0,  0, 32'h0,         0, 0, 0, 1, 56'h83_01_44_00000000,  4, 3'd0, 8'd3);
        add_vec(56'h55_FF_10_00000000, 0,  0, 32'h0,         1, 0, 0, 0, 56'h0,                 -1, 3'd2, 8'd4);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_cmd(tbl[i].cmd, tbl[i].crc, tbl[i].rd_lat, tbl[i].rdata, tbl[i].tx_dly, 1'b0, 56'h0);
            check_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // Second command during TX_WAIT: dropped, first response unaffected
        cur.cmd = 56'h03_01_66_00000000; cur.crc = 0; cur.rd_lat = 0; cur.rdata = 32'h0;
        cur.tx_dly = 3; cur.we = 0; cur.re = 0; cur.tx = 1; cur.frame = 56'h83_01_66_00000000;
        cur.lat = 4; cur.status = 3'd0; cur.err = 8'd5;
        run_cmd(cur.cmd, cur.crc, cur.rd_lat, cur.rdata, cur.tx_dly, 1'b1, 56'h01_01_77_CAFEF00D);
        check_txn("drop_in_txwait", cur);

        // Transmit path never answers
        cur.cmd = 56'h01_01_20_00000099; cur.tx_dly = NO_RESP; cur.we = 1;
        cur.frame = 56'h81_01_20_00000099; cur.status = 3'd4; cur.err = 8'd6;
        run_cmd(cur.cmd, cur.crc, cur.rd_lat, cur.rdata, cur.tx_dly, 1'b0, 56'h0);
        check_txn("tx_timeout", cur);

        // Randomized commands against the reference model
        m_status = 3'd4; m_err = 6;
        for (int i = 0; i < 120; i++) begin
            logic [7:0] op, dev;
            int r;
            r   = $urandom_range(0, 9);
            dev = (r < 6) ? 8'h01 : (r < 8) ? 8'hFF : 8'($urandom());
            r   = $urandom_range(0, 11);
            op  = (r < 10) ? 8'(1 + (r % 3)) : 8'($urandom());
            cur.cmd    = {op, dev, 8'($urandom()), 32'($urandom())};
            cur.crc    = ($urandom_range(0, 7) == 0);
            cur.rd_lat = $urandom_range(1, 20);
            cur.rdata  = $urandom();
            cur.tx_dly = $urandom_range(0, 5);
            model(cur, expv);
            run_cmd(cur.cmd, cur.crc, cur.rd_lat, cur.rdata, cur.tx_dly, 1'b0, 56'h0);
            check_txn($sformatf("rnd%0d", i), expv);
        end

        // Reset while waiting for read data, then a late rvalid
        @(negedge clk);
        i_command = 56'h02_01_22_00000000; i_cmd_valid = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rdwait.busy_before_reset", o_busy, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("reset_in_rdwait");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        i_reg_rvalid = 1'b1; i_reg_rdata = 32'hFEEDFACE;
        @(negedge clk);
        i_reg_rvalid = 1'b0;
        repeat (5) @(negedge clk);
        chk("late_rvalid.tx_req", o_tx_req, 0);
        chk("late_rvalid.busy", o_busy, 0);
        chk("late_rvalid.status", o_status, 0);

        // Error counter saturation
        for (int i = 1; i <= 300; i++) begin
            run_cmd(56'h03_01_00_00000000, 1'b1, 0, 32'h0, 0, 1'b0, 56'h0);
            if (i == 254) chk("sat.err_254", o_err_count, 8'hFE);
            if (i == 255) chk("sat.err_255", o_err_count, 8'hFF);
        end
        chk("sat.err_300", o_err_count, 8'hFF);
        chk("sat.status", o_status, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onewire_slave_seq.md
Name: onewire_slave_seq

Overview:
Command sequencer for the 1-Wire slave. It sits after the slave receive path and takes each decoded 56-bit command together with its CRC-error flag. It filters commands by device address, executes register reads and writes on the slave register file, and hands a 56-bit response frame to the slave transmit path. It also tracks errors, timeouts and dropped commands.

Parameters:
DEV_ADDR, 8'h01, this slave's device address.
BCAST_ADDR, 8'hFF, broadcast address: writes are accepted, no response is sent.
RD_TIMEOUT, 16, maximum cycles from o_reg_re to i_reg_rvalid.
TX_TIMEOUT, 4096, maximum cycles from o_tx_req to i_tx_done.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
i_cmd_valid  input  1  one-cycle strobe: i_command and i_crc_error are valid.
i_command  input  56  [55:48] opcode, [47:40] device addr, [39:32] reg addr, [31:0] data.
i_crc_error  input  1  received CRC mismatch, qualified by i_cmd_valid.
o_reg_we  output  1  register write strobe, 1 cycle.
o_reg_re  output  1  register read strobe, 1 cycle.
o_reg_addr  output  8  register address.
o_reg_wdata  output  32  register write data.
i_reg_rdata  input  32  read data, qualified by i_reg_rvalid.
i_reg_rvalid  input  1  read data valid, 1 cycle.
o_tx_req  output  1  level: response frame pending; held until i_tx_done.
o_tx_frame  output  56  response frame, stable while o_tx_req=1.
i_tx_done  input  1  transmit path finished the frame, 1 cycle.
o_busy  output  1  high in every state except IDLE.
o_status  output  3  result of the last command.
o_err_count  output  8  saturating count of CRC, opcode, timeout and drop events.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output is 0.
- Status codes: 0 OK, 1 CRC error, 2 bad opcode, 3 read timeout, 4 tx timeout, 5 dropped (command arrived while busy).
- Opcodes: 8'h01 WRITE, 8'h02 READ, 8'h03 PING.
- IDLE: on i_cmd_valid, latch the command and error flag, then go to CHECK.
- CHECK (1 cycle):
  - CRC error: status=1, err_count+1, go to IDLE. Address is not checked; no response.
  - Address is neither DEV_ADDR nor BCAST_ADDR: go to IDLE silently; status and counter unchanged.
  - Opcode not 01/02/03: status=2, err_count+1. Response is sent (see RESP) unless broadcast.
  - Broadcast with READ or PING: ignored silently.
  - Otherwise go to EXEC.
- EXEC:
  - WRITE: o_reg_we=1 for one cycle with o_reg_addr=cmd[39:32] and o_reg_wdata=cmd[31:0]. Broadcast write: status=0, go to IDLE. Addressed write: go to RESP, echoing the write data.
  - READ: o_reg_re=1 for one cycle, go to RD_WAIT.
  - PING: go to RESP with data=32'h0.
- RD_WAIT:
  - Capture i_reg_rdata on i_reg_rvalid, go to RESP.
  - i_reg_rvalid may arrive in the same cycle as o_reg_re+1 at the earliest.
  - If there is no rvalid within RD_TIMEOUT cycles: status=3, err_count+1, go to IDLE with no response.
- RESP (1 cycle):
  - o_tx_frame = {opcode|8'h80, DEV_ADDR, reg addr, data}.
  - Bad-opcode frame = {8'hEE, DEV_ADDR, received opcode, 24'h0}.
  - o_tx_req=1, go to TX_WAIT.
- TX_WAIT:
  - Hold o_tx_req and o_tx_frame stable.
  - On i_tx_done: drop o_tx_req next cycle; status=0 (or keep 2 for bad opcode); go to IDLE.
  - If TX_TIMEOUT elapses: drop o_tx_req, status=4, err_count+1, go to IDLE.
- i_cmd_valid in any state other than IDLE: the command is discarded, status=5, err_count+1. The in-flight command continues, and its final status overwrites 5.
- i_cmd_valid in the same cycle the FSM returns to IDLE: discarded as busy. Acceptance requires the registered state to be IDLE.
- o_err_count saturates at 8'hFF with no wrap.
- The timeout counter clears on every state entry. The comparison is reached-count, so exactly RD_TIMEOUT cycles without rvalid trigger the timeout.
- i_tx_done, i_reg_rvalid or i_cmd_valid arriving mid-transaction during reset are ignored; reset aborts any transaction without a response.
- Latency: from i_cmd_valid to o_tx_req, PING/WRITE takes 4 cycles and READ takes 4 cycles + read latency.

Test Plan:
- Write: i_command=56'h01_01_10_DEADBEEF, no CRC error -> o_reg_we for 1 cycle with addr 8'h10 and wdata 32'hDEADBEEF; o_tx_frame=56'h81_01_10_DEADBEEF; on i_tx_done, o_status=0 and o_busy=0.
- Read: 56'h02_01_22_00000000 with rvalid 3 cycles after re and rdata=32'h12345678 -> o_tx_frame=56'h82_01_22_12345678. A second read with no rvalid -> o_status=3 after 16 cycles, o_err_count=1, no o_tx_req.
- Address filtering: 56'h01_05_10_00000001 -> no strobes, no tx, status unchanged. Broadcast 56'h01_FF_10_00000001 -> o_reg_we pulses, no o_tx_req. Broadcast 56'h02_FF_… -> ignored.
- Errors: CRC error on a valid PING -> o_status=1, o_err_count+1, no tx. Opcode 8'h7A -> o_tx_frame=56'hEE_01_7A_000000, o_status=2.
- Concurrency and timeout: a second i_cmd_valid during TX_WAIT -> o_err_count+1 and the first response completes intact. Holding i_tx_done low for 4096 cycles -> o_tx_req drops and o_status=4.
- Reset and saturation: assert reset in RD_WAIT -> all outputs 0 immediately, and a late rvalid is ignored. Send 300 CRC-error commands -> o_err_count=8'hFF.
